// File: rtl/men_arb_sched.sv
// men_arb_sched: round-robin arbiter that hands the memory subsystem to one
// requester at a time. It latches the transfer configuration and steers the
// write and read word strobes between the granted requester and memory.
module men_arb_sched #(
  parameter int N_REQ = 3,
  parameter int IDX_W = 2
) (
  input  logic                  clk_150_0,
  input  logic                  reset,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ-1:0]      req_write,
  input  logic [2*N_REQ-1:0]    req_src,
  input  logic [32*N_REQ-1:0]   req_addr,
  input  logic [16*N_REQ-1:0]   req_len,
  input  logic [16*N_REQ-1:0]   req_wdata,
  input  logic [N_REQ-1:0]      req_wstb,
  input  logic [N_REQ-1:0]      req_rstb,
  output logic [N_REQ-1:0]      grant,
  output logic [N_REQ-1:0]      wready,
  output logic [N_REQ-1:0]      rvalid,
  output logic [15:0]           rdata,
  output logic [N_REQ-1:0]      done,
  output logic                  men_start,
  output logic                  men_read,
  output logic                  men_write,
  output logic                  men_req_vaild,
  output logic [15:0]           men_pro_length,
  output logic [31:0]           men_wr_start_addr,
  output logic [31:0]           men_rd_start_addr,
  output logic                  men_write_source,
  output logic [1:0]            men_read_source,
  output logic [15:0]           men_write_data,
  input  logic                  men_write_ddr_en,
  input  logic                  men_read_ready,
  input  logic                  men_read_quit,
  input  logic [15:0]           men_read_data
);

  typedef enum logic [1:0] {IDLE, START, XFER, DONE} state_t;

  state_t           state;
  logic [IDX_W-1:0] idx, last_grant, pick, cand;
  logic             found, is_wr, wacc;
  logic [15:0]      cnt;
  logic [15:0]      pick_len;
  logic [31:0]      pick_addr;
  logic [1:0]       pick_src;
  logic [15:0]      cur_wdata;

  assign pick_len  = req_len[16*pick +: 16];
  assign pick_addr = req_addr[32*pick +: 32];
  assign pick_src  = req_src[2*pick +: 2];
  assign cur_wdata = req_wdata[16*idx +: 16];

  // Round-robin pick: first valid requester searching upward from last_grant+1.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      cand = IDX_W'((int'(last_grant) + i) % N_REQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Data-path steering while a transfer is active; only the owner sees strobes.
  always_comb begin
    wready         = '0;
    rvalid         = '0;
    rdata          = '0;
    men_write      = 1'b0;
    men_read       = 1'b0;
    men_write_data = '0;
    wacc           = 1'b0;
    if (state == XFER) begin
      if (is_wr) begin
        wacc           = req_wstb[idx] & (men_write_source | men_write_ddr_en);
        wready[idx]    = wacc;
        men_write      = wacc;
        men_write_data = cur_wdata;
      end else begin
        men_read       = req_rstb[idx];
        rvalid[idx]    = men_read_ready;
        rdata          = men_read_data;
      end
    end
  end

  // Control FSM with registered grant, configuration and pulse outputs.
  always_ff @(posedge clk_150_0 or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      idx               <= '0;
      last_grant        <= IDX_W'(N_REQ-1);
      is_wr             <= 1'b0;
      cnt               <= '0;
      grant             <= '0;
      done              <= '0;
      men_start         <= 1'b0;
      men_req_vaild     <= 1'b0;
      men_pro_length    <= '0;
      men_wr_start_addr <= '0;
      men_rd_start_addr <= '0;
      men_write_source  <= 1'b0;
      men_read_source   <= '0;
    end else begin
      case (state)
        IDLE: if (found) begin
          idx               <= pick;
          grant             <= N_REQ'(1) << pick;
          is_wr             <= req_write[pick];
          cnt               <= pick_len;
          men_pro_length    <= pick_len;
          men_wr_start_addr <= pick_addr;
          men_rd_start_addr <= pick_addr;
          men_write_source  <= pick_src[0];
          men_read_source   <= pick_src;
          if (pick_len != '0) begin
            state     <= START;
            men_start <= 1'b1;
          end else begin
            // Empty transfer: report completion without touching memory.
            state         <= DONE;
            done          <= N_REQ'(1) << pick;
            men_req_vaild <= ~req_write[pick];
            last_grant    <= pick;
          end
        end
        START: begin
          men_start <= 1'b0;
          state     <= XFER;
        end
        XFER: begin
          if (wacc) cnt <= cnt - 16'd1;
          if ((is_wr && wacc && cnt == 16'd1) || (!is_wr && men_read_quit)) begin
            state         <= DONE;
            done          <= grant;
            men_req_vaild <= ~is_wr;
            last_grant    <= idx;
          end
        end
        DONE: begin
          done          <= '0;
          men_req_vaild <= 1'b0;
          grant         <= '0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_men_arb_sched.sv
// Directed bench for men_arb_sched: write, round robin, ddr backpressure,
// read with quit, zero length and mid-transfer reset.
module tb_men_arb_sched;
  localparam int N = 3;

  logic            clk_150_0 = 1'b0, reset = 1'b0;
  logic [N-1:0]    req_valid = '0, req_write = '0, req_wstb = '0, req_rstb = '0;
  logic [2*N-1:0]  req_src = '0;
  logic [32*N-1:0] req_addr = '0;
  logic [16*N-1:0] req_len = '0, req_wdata = '0;
  logic [N-1:0]    grant, wready, rvalid, done;
  logic [15:0]     rdata, men_pro_length, men_write_data, men_read_data = '0;
  logic            men_start, men_read, men_write, men_req_vaild, men_write_source;
  logic [31:0]     men_wr_start_addr, men_rd_start_addr;
  logic [1:0]      men_read_source;
  logic            men_write_ddr_en = 1'b0, men_read_ready = 1'b0, men_read_quit = 1'b0;

  men_arb_sched #(.N_REQ(N), .IDX_W(2)) dut (
    .clk_150_0(clk_150_0), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_src(req_src),
    .req_addr(req_addr), .req_len(req_len), .req_wdata(req_wdata),
    .req_wstb(req_wstb), .req_rstb(req_rstb),
    .grant(grant), .wready(wready), .rvalid(rvalid), .rdata(rdata), .done(done),
    .men_start(men_start), .men_read(men_read), .men_write(men_write),
    .men_req_vaild(men_req_vaild), .men_pro_length(men_pro_length),
    .men_wr_start_addr(men_wr_start_addr), .men_rd_start_addr(men_rd_start_addr),
    .men_write_source(men_write_source), .men_read_source(men_read_source),
    .men_write_data(men_write_data), .men_write_ddr_en(men_write_ddr_en),
    .men_read_ready(men_read_ready), .men_read_quit(men_read_quit),
    .men_read_data(men_read_data));

  always #5 clk_150_0 = ~clk_150_0;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Per-cycle event monitor, sampled on the falling edge.
  int cyc, n_start, start_cyc, n_wready, n_mwr, n_done, done_cyc, n_rvm, n_bad;
  logic [N-1:0] last_done, prev_g;
  logic [15:0]  wd_seen;
  logic [N-1:0] gq[$];

  task automatic clr();
    cyc = 0; n_start = 0; start_cyc = 0; n_wready = 0; n_mwr = 0; n_done = 0;
    done_cyc = 0; n_rvm = 0; n_bad = 0; last_done = '0; wd_seen = '0; gq.delete();
  endtask

  always @(negedge clk_150_0) begin
    cyc++;
    if (men_start) begin n_start++; start_cyc = cyc; end
    if (|wready) n_wready++;
    if (men_write) begin n_mwr++; wd_seen = men_write_data; end
    if (done != '0) begin n_done++; done_cyc = cyc; last_done = done; end
    if (men_req_vaild) n_rvm++;
    if (((wready | rvalid) & ~grant) != '0) n_bad++;
    if (grant != '0 && grant != prev_g) gq.push_back(grant);
    prev_g = grant;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk_150_0);
    #1;
  endtask

  task automatic set_req(input int i, input logic wr, input logic [1:0] src,
                         input logic [31:0] addr, input logic [15:0] len, input logic [15:0] wd);
    req_write[i] = wr;
    req_src[2*i +: 2] = src;
    req_addr[32*i +: 32] = addr;
    req_len[16*i +: 16] = len;
    req_wdata[16*i +: 16] = wd;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step(2);
    reset = 1'b1;
  endtask

  initial begin
    prev_g = '0;
    clr();
    // Reset state
    step(1);
    @(negedge clk_150_0);
    chk("rst_grant", grant, 0);
    chk("rst_done", done, 0);
    chk("rst_strobes", {men_start, men_read, men_write, men_req_vaild}, 0);
    chk("rst_cfg", {men_pro_length, men_write_source, men_read_source}, 0);
    chk("rst_addr", men_wr_start_addr | men_rd_start_addr, 0);
    chk("rst_data", {rdata, men_write_data}, 0);
    step(1);
    reset = 1'b1;
    step(1);

    // Single write to ram, len 3; req1 strobes while not granted
    clr();
    set_req(0, 1'b1, 2'b01, 32'h10, 16'd3, 16'hA5A5);
    req_valid = 3'b001; req_wstb = 3'b011;
    step(1);
    req_valid = '0;
    step(8);
    chk("wr_nstart", n_start, 1);
    chk("wr_start_cyc", start_cyc, 2);
    chk("wr_nwready", n_wready, 3);
    chk("wr_nmwr", n_mwr, 3);
    chk("wr_wdata", wd_seen, 16'hA5A5);
    chk("wr_done_cyc", done_cyc, 6);
    chk("wr_done_vec", last_done, 3'b001);
    chk("wr_ndone", n_done, 1);
    chk("wr_no_rvm", n_rvm, 0);
    chk("wr_nongrant", n_bad, 0);
    chk("wr_cfg_len", men_pro_length, 3);
    chk("wr_cfg_addr", men_wr_start_addr, 32'h10);
    chk("wr_cfg_src", men_write_source, 1);
    req_wstb = '0;

    // Round robin from reset
    do_reset();
    clr();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 2'b01, 32'h100 * i, 16'd1, 16'h0);
    req_wstb = 3'b111; req_valid = 3'b111;
    step(20);
    req_valid = '0;
    step(6);
    req_wstb = '0;
    chk("rr_count", gq.size() >= 4, 1);
    if (gq.size() >= 4) begin
      chk("rr_g0", gq[0], 3'b001);
      chk("rr_g1", gq[1], 3'b010);
      chk("rr_g2", gq[2], 3'b100);
      chk("rr_g3", gq[3], 3'b001);
    end
    chk("rr_nongrant", n_bad, 0);

    // DDR backpressure: write len 2, ddr_en low for 4 transfer cycles
    clr();
    set_req(0, 1'b1, 2'b00, 32'h40, 16'd2, 16'h1234);
    men_write_ddr_en = 1'b0; req_wstb = 3'b001; req_valid = 3'b001;
    step(1);
    req_valid = '0;
    step(1);
    step(4);
    chk("ddr_hold_wready", n_wready, 0);
    chk("ddr_hold_done", n_done, 0);
    chk("ddr_src", men_write_source, 0);
    men_write_ddr_en = 1'b1;
    step(6);
    chk("ddr_nwready", n_wready, 2);
    chk("ddr_done_cyc", done_cyc, 9);
    chk("ddr_done_vec", last_done, 3'b001);
    men_write_ddr_en = 1'b0; req_wstb = '0;

    // Read: req1 from ad, len 4, quit on transfer cycle 9
    clr();
    set_req(1, 1'b0, 2'b10, 32'h200, 16'd4, 16'h0);
    req_rstb = 3'b010; req_valid = 3'b010;
    step(1);
    req_valid = '0;
    step(1);
    for (int k = 1; k <= 9; k++) begin
      men_read_ready = k[0];
      men_read_quit  = (k == 9);
      men_read_data  = 16'h1000 + 16'(k);
      @(negedge clk_150_0);
      chk("rd_rvalid", rvalid, {1'b0, k[0], 1'b0});
      chk("rd_rdata", rdata, 16'h1000 + 16'(k));
      chk("rd_men_read", men_read, 1);
      step(1);
    end
    men_read_quit = 1'b0; men_read_ready = 1'b0;
    @(negedge clk_150_0);
    chk("rd_done", done, 3'b010);
    chk("rd_rvm", men_req_vaild, 1);
    chk("rd_quiet", {men_read, rvalid}, 0);
    step(1);
    @(negedge clk_150_0);
    chk("rd_done_clr", {done, men_req_vaild}, 0);
    chk("rd_nstart", n_start, 1);
    chk("rd_cfg", {men_read_source, men_pro_length}, {2'b10, 16'd4});
    chk("rd_addr", men_rd_start_addr, 32'h200);
    req_rstb = '0;
    step(1);

    // Zero length on req2
    clr();
    set_req(2, 1'b1, 2'b01, 32'h0, 16'd0, 16'h0);
    req_valid = 3'b100;
    step(1);
    req_valid = '0;
    step(4);
    chk("zl_nstart", n_start, 0);
    chk("zl_done_cyc", done_cyc, 2);
    chk("zl_done_vec", last_done, 3'b100);
    chk("zl_ndone", n_done, 1);

    // Reset mid-transfer, then regrant starts at index 0
    clr();
    set_req(0, 1'b1, 2'b01, 32'h80, 16'd5, 16'hBEEF);
    req_wstb = 3'b001; req_valid = 3'b001;
    step(1);
    req_valid = '0;
    step(2);
    reset = 1'b0;
    @(negedge clk_150_0);
    chk("mr_grant", grant, 0);
    chk("mr_out", {wready, rvalid, done}, 0);
    chk("mr_strobes", {men_start, men_write, men_read, men_req_vaild}, 0);
    chk("mr_cfg", {men_pro_length, men_write_data, rdata}, 0);
    step(2);
    reset = 1'b1;
    req_wstb = '0;
    step(1);
    chk("mr_done_none", n_done + n_rvm, 0);
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 2'b01, 32'h0, 16'd0, 16'h0);
    req_valid = 3'b111;
    step(1);
    req_valid = '0;
    @(negedge clk_150_0);
    chk("mr_regrant", grant, 3'b001);
    step(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
